// File: rtl/ram_pkg.sv
// Shared definitions for the RAM copy/fill engine: default geometry, FSM states and command ops.
package ram_pkg;

  localparam int unsigned DefRamSize = 3072;
  localparam int unsigned DefAddrW   = 12;
  localparam int unsigned DefDataW   = 16;

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} copy_state_t;

  typedef enum logic {OP_COPY, OP_FILL} ram_op_t;

endpackage

// File: rtl/ram_copy_engine.sv
// Copy/fill initiator for a single-port synchronous RAM with 1-cycle registered read.
// Sequences one RAM access per cycle and keeps a running sum of the words written.
module ram_copy_engine
  import ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE = DefRamSize,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] sum,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W+1:0] SizeExt = RAM_SIZE[ADDR_W+1:0];
  localparam logic [ADDR_W:0]   IdxOne  = {{ADDR_W{1'b0}}, 1'b1};

  copy_state_t       state_q, state_d;
  ram_op_t           op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] pat_q, pat_d, sum_q, sum_d;
  logic              err_q, err_d;
  logic [ADDR_W+1:0] src_end, dst_end;
  logic              last;

  // Bounds are checked one bit wider than the sum can reach so no wrap hides an overrun.
  assign src_end = {2'b00, cmd_src} + {1'b0, cmd_len};
  assign dst_end = {2'b00, cmd_dst} + {1'b0, cmd_len};
  assign last    = (idx_q == (len_q - IdxOne));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    sum_d     = sum_q;
    err_d     = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            sum_d   = '0;
            state_d = FINISH;
          end else if ((dst_end > SizeExt) ||
                       ((cmd_op == OP_COPY) && (src_end > SizeExt))) begin
            err_d = 1'b1;
          end else begin
            op_d    = ram_op_t'(cmd_op);
            src_d   = cmd_src;
            dst_d   = cmd_dst;
            len_d   = cmd_len;
            pat_d   = cmd_pattern;
            idx_d   = '0;
            sum_d   = '0;
            state_d = (cmd_op == OP_COPY) ? READ : WRITE;
          end
        end
      end
      READ: begin
        ram_addr = src_q + idx_q[ADDR_W-1:0];
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram_addr  = dst_q + idx_q[ADDR_W-1:0];
        ram_wdata = (op_q == OP_COPY) ? ram_rdata : pat_q;
        sum_d     = sum_q + ram_wdata;
        idx_d     = idx_q + IdxOne;
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          state_d = FINISH;
        end else begin
          state_d = (op_q == OP_COPY) ? READ : WRITE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign err       = err_q;
  assign sum       = sum_q;
  assign ram_rden  = (state_q == READ);
  assign ram_wren  = (state_q == WRITE);

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: behavioural single-port RAM plus a write scoreboard.
module tb_ram_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [11:0] cmd_src = '0;
  logic [11:0] cmd_dst = '0;
  logic [12:0] cmd_len = '0;
  logic [15:0] cmd_pattern = '0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [15:0] sum;
  logic        ram_rden, ram_wren;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [0:3071];

  logic [27:0] exp_q[$];
  logic [27:0] act_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ram_copy_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_pattern(cmd_pattern),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sum        (sum),
    .ram_rden   (ram_rden),
    .ram_wren   (ram_wren),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // RAM model: write has priority over read; read data registered.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    else if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input int a, input logic [15:0] d);
    @(negedge clk);
    pre_addr = a[11:0];
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic op, input int src, input int dst, input int len,
                       input logic [15:0] pat);
    @(negedge clk);
    cmd_op      = op;
    cmd_src     = src[11:0];
    cmd_dst     = dst[11:0];
    cmd_len     = len[12:0];
    cmd_pattern = pat;
    cmd_valid   = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Watches the cycles after an accept edge; cycle 1 is the first cycle after that edge.
  task automatic observe(input int max_cyc, input int abort_at, output int done_at,
                         output int err_at, output int rd_n, output int wr_n,
                         output int both_n, output int done_n, output int err_n);
    done_at = 0; err_at = 0; rd_n = 0; wr_n = 0; both_n = 0; done_n = 0; err_n = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (ram_rden) rd_n++;
      if (ram_wren) begin
        wr_n++;
        act_q.push_back({ram_addr, ram_wdata});
      end
      if (ram_rden && ram_wren) both_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (err) begin
        err_n++;
        if (err_at == 0) err_at = c;
      end
      abort = (abort_at != 0) && (wr_n == abort_at) && ram_wren;
      if ((done_at != 0 && c == done_at + 2) || (err_at != 0 && c == err_at + 2)) break;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
    checks++; if ({ram_rden, ram_wren} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {ram_rden, ram_wren}); end
    checks++; if ({ram_addr, ram_wdata, sum} !== 44'h0) begin errors++; $display("FAIL reset_buses got %h want 0", {ram_addr, ram_wdata, sum}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_fill();
    int d, e, r, w, b, dn, en;
    logic [15:0] s = '0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({12'(100 + i), 16'hA5A5});
      s += 16'hA5A5;
    end
    issue(1'b1, 0, 100, 4, 16'hA5A5);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b want 1", busy); end
    observe(40, 0, d, e, r, w, b, dn, en);
    checks++; if (d !== 5) begin errors++; $display("FAIL fill_done_cycle got %0d want 5", d); end
    checks++; if (dn !== 1 || e !== 0) begin errors++; $display("FAIL fill_pulses got done=%0d err=%0d want 1/0", dn, e); end
    checks++; if (sum !== 16'h9694 || sum !== s) begin errors++; $display("FAIL fill_sum got %h want 9694", sum); end
    checks++; if (r !== 0 || b !== 0) begin errors++; $display("FAIL fill_reads got rd=%0d both=%0d want 0/0", r, b); end
    while (exp_q.size() > 0) begin
      logic [27:0] ex, ac;
      ex = exp_q.pop_front();
      ac = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      checks++; if (ac !== ex) begin errors++; $display("FAIL fill_write got %h want %h", ac, ex); end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL fill_extra got %0d want 0", act_q.size()); end
    act_q.delete();
    for (int i = 100; i < 104; i++) begin
      checks++; if (mem[i] !== 16'hA5A5) begin errors++; $display("FAIL fill_mem[%0d] got %h want a5a5", i, mem[i]); end
    end
  endtask

  task automatic test_copy();
    int d, e, r, w, b, dn, en;
    preload(0, 16'd1); preload(1, 16'd2); preload(2, 16'd3);
    for (int i = 0; i < 3; i++) exp_q.push_back({12'(10 + i), 16'(i + 1)});
    issue(1'b0, 0, 10, 3, 16'hFFFF);
    observe(40, 0, d, e, r, w, b, dn, en);
    checks++; if (d !== 7) begin errors++; $display("FAIL copy_done_cycle got %0d want 7", d); end
    checks++; if (sum !== 16'd6) begin errors++; $display("FAIL copy_sum got %h want 0006", sum); end
    checks++; if (r !== 3 || b !== 0) begin errors++; $display("FAIL copy_reads got rd=%0d both=%0d want 3/0", r, b); end
    while (exp_q.size() > 0) begin
      logic [27:0] ex, ac;
      ex = exp_q.pop_front();
      ac = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      checks++; if (ac !== ex) begin errors++; $display("FAIL copy_write got %h want %h", ac, ex); end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL copy_extra got %0d want 0", act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_boundaries();
    int d, e, r, w, b, dn, en;
    // Destination overrun, then source overrun: both must be refused with no RAM traffic.
    issue(1'b0, 0, 3070, 3, 16'h0);
    observe(20, 0, d, e, r, w, b, dn, en);
    checks++; if (e !== 1 || en !== 1 || dn !== 0) begin errors++; $display("FAIL rej_dst got err_at=%0d errs=%0d dones=%0d want 1/1/0", e, en, dn); end
    checks++; if (r !== 0 || w !== 0) begin errors++; $display("FAIL rej_dst_access got rd=%0d wr=%0d want 0/0", r, w); end
    checks++; if (sum !== 16'd6) begin errors++; $display("FAIL rej_sum got %h want 0006", sum); end
    issue(1'b0, 3070, 0, 3, 16'h0);
    observe(20, 0, d, e, r, w, b, dn, en);
    checks++; if (e !== 1 || r !== 0 || w !== 0) begin errors++; $display("FAIL rej_src got err_at=%0d rd=%0d wr=%0d want 1/0/0", e, r, w); end
    act_q.delete();
    // Exactly reaching the last word is legal.
    for (int i = 0; i < 3; i++) exp_q.push_back({12'(3069 + i), 16'h00FF});
    issue(1'b1, 0, 3069, 3, 16'h00FF);
    observe(20, 0, d, e, r, w, b, dn, en);
    checks++; if (d !== 4 || e !== 0 || sum !== 16'h02FD) begin errors++; $display("FAIL edge_fill got done_at=%0d err_at=%0d sum=%h want 4/0/02fd", d, e, sum); end
    while (exp_q.size() > 0) begin
      logic [27:0] ex, ac;
      ex = exp_q.pop_front();
      ac = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      checks++; if (ac !== ex) begin errors++; $display("FAIL edge_write got %h want %h", ac, ex); end
    end
    act_q.delete();
    issue(1'b0, 0, 0, 0, 16'h0);
    observe(20, 0, d, e, r, w, b, dn, en);
    checks++; if (d !== 1 || dn !== 1 || e !== 0) begin errors++; $display("FAIL len0 got done_at=%0d dones=%0d err_at=%0d want 1/1/0", d, dn, e); end
    checks++; if (r !== 0 || w !== 0 || sum !== 16'h0) begin errors++; $display("FAIL len0_access got rd=%0d wr=%0d sum=%h want 0/0/0", r, w, sum); end
  endtask

  task automatic test_overlap();
    int d, e, r, w, b, dn, en;
    logic [15:0] v [0:4];
    v[0] = 16'd7;
    for (int i = 1; i < 5; i++) v[i] = 16'($urandom_range(100, 999));
    for (int i = 0; i < 5; i++) preload(i, v[i]);
    for (int i = 0; i < 4; i++) begin
      v[i + 1] = v[i];
      exp_q.push_back({12'(1 + i), v[i + 1]});
    end
    issue(1'b0, 0, 1, 4, 16'h0);
    observe(40, 0, d, e, r, w, b, dn, en);
    checks++; if (d !== 9) begin errors++; $display("FAIL ovl_done_cycle got %0d want 9", d); end
    while (exp_q.size() > 0) begin
      logic [27:0] ex, ac;
      ex = exp_q.pop_front();
      ac = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      checks++; if (ac !== ex) begin errors++; $display("FAIL ovl_write got %h want %h", ac, ex); end
    end
    act_q.delete();
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem[i] !== 16'd7) begin errors++; $display("FAIL ovl_mem[%0d] got %h want 0007", i, mem[i]); end
    end
  endtask

  task automatic test_abort();
    int d, e, r, w, b, dn, en;
    logic [15:0] s = '0;
    preload(210, 16'h0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({12'(200 + i), 16'h1234});
      s += 16'h1234;
    end
    issue(1'b1, 0, 200, 50, 16'h1234);
    observe(100, 10, d, e, r, w, b, dn, en);
    checks++; if (w !== 10) begin errors++; $display("FAIL abort_writes got %0d want 10", w); end
    checks++; if (e !== 11 || en !== 1 || dn !== 0) begin errors++; $display("FAIL abort_pulses got err_at=%0d errs=%0d dones=%0d want 11/1/0", e, en, dn); end
    checks++; if (sum !== s) begin errors++; $display("FAIL abort_sum got %h want %h", sum, s); end
    checks++; if (mem[209] !== 16'h1234 || mem[210] !== 16'h0) begin errors++; $display("FAIL abort_mem got %h/%h want 1234/0000", mem[209], mem[210]); end
    while (exp_q.size() > 0) begin
      logic [27:0] ex, ac;
      ex = exp_q.pop_front();
      ac = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      checks++; if (ac !== ex) begin errors++; $display("FAIL abort_write got %h want %h", ac, ex); end
    end
    act_q.delete();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 0, 500, 40, 16'h0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err, ram_rden, ram_wren} !== 5'b0) begin errors++; $display("FAIL midrst_flags got %b want 00000", {busy, done, err, ram_rden, ram_wren}); end
    checks++; if ({ram_addr, ram_wdata, sum} !== 44'h0) begin errors++; $display("FAIL midrst_buses got %h want 0", {ram_addr, ram_wdata, sum}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ready got ready=%b busy=%b want 1/0", cmd_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_boundaries();
    test_overlap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
